hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline hazard controller sitting directly downstream of the forwarding unit.
//   Turns load-use, branch-taken and memory-wait requests into per-stage stall and flush controls.
//   Owns the WB lock register: captures the WB result that would be lost during a load-use stall.
//   Replays it to the forwarding unit via lock_forward_signal/lock_forward_rs/lock_forward_data.
//   Keeps saturating stall/flush performance counters.
// PARAMETERS
//   DATA_W  32  width of register data captured by the lock register
//   CNT_W   32  width of each performance counter
// PORTS
//   clk                      in   1       clock; all state updates on rising edge
//   rst                      in   1       synchronous reset, active-high
//   load_use_stall_flush     in   1       load-use hazard detected by forwarding unit
//   load_use_wb_lock_signal  in   1       other EX source is forwarded from WB and must be locked
//   load_use_rs_lock_num     in   1       which EX source to lock: 0=rs1, 1=rs2
//   WB_rd_data               in   DATA_W  value currently being written back
//   branch_taken             in   1       EX-stage branch/jump resolved taken
//   IM_stall                 in   1       instruction memory not ready
//   DM_stall                 in   1       data memory not ready
//   PC_stall                 out  1       hold PC
//   IF_ID_stall              out  1       hold IF/ID register
//   ID_EX_stall              out  1       hold ID/EX register
//   EX_MEM_stall             out  1       hold EX/MEM register
//   MEM_WB_stall             out  1       hold MEM/WB register
//   IF_ID_flush              out  1       load bubble into IF/ID
//   ID_EX_flush              out  1       load bubble into ID/EX
//   EX_MEM_flush             out  1       load bubble into EX/MEM
//   lock_forward_signal      out  1       lock register valid; forward it to EX
//   lock_forward_rs          out  1       EX source receiving lock data: 0=rs1, 1=rs2
//   lock_forward_data        out  DATA_W  captured WB value
//   stall_cnt                out  CNT_W   cycles with any stall asserted, saturating
//   flush_cnt                out  CNT_W   branch flush events, saturating
// BEHAVIOUR
//   Stall/flush outputs are combinational from inputs and state.
//   Lock outputs and counters are registered.
//   mem_wait = IM_stall | DM_stall.
//   Masked load-use: lu = load_use_stall_flush & (state==IDLE).
//   Priority, highest first:
//     1. rst: all stall/flush outputs 0.
//     2. mem_wait: all five *_stall=1, all flushes=0; counters and lock state frozen except stall_cnt.
//     3. lu: PC_stall=IF_ID_stall=ID_EX_stall=1, EX_MEM_flush=1; MEM_WB advances.
//        branch_taken is ignored this cycle, since the EX instr is not yet valid.
//     4. branch_taken: IF_ID_flush=ID_EX_flush=1; nothing stalled.
//     5. otherwise: all 0.
//   FSM:
//     IDLE -> LOCKED when lu & load_use_wb_lock_signal & !mem_wait.
//       On that edge: lock_forward_data<=WB_rd_data, lock_forward_rs<=load_use_rs_lock_num.
//     LOCKED -> IDLE on first cycle with !mem_wait, i.e. when the EX instr advances.
//       Stays LOCKED while mem_wait holds EX.
//     lu without load_use_wb_lock_signal: one-cycle stall only, state stays IDLE.
//   lock_forward_signal = (state==LOCKED). lock_forward_data/rs hold value until the next capture.
//   Counters:
//     stall_cnt += 1 when any *_stall=1.
//     flush_cnt += 1 when IF_ID_flush=1.
//     Both saturate at 2^CNT_W-1 and never wrap.
//   Reset: state=IDLE, lock_forward_signal=0, lock_forward_rs=0, lock_forward_data=0, counters=0.
//     Reset mid-LOCKED drops the lock immediately on that edge.
// TESTING
//   lu=1, wb_lock=1, rs_lock_num=1, WB_rd_data=0xDEADBEEF.
//     -> same cycle: PC/IF_ID/ID_EX_stall=1, EX_MEM_flush=1.
//     -> next cycle: lock_forward_signal=1, rs=1, data=0xDEADBEEF; cycle after: signal=0.
//   Same as above with DM_stall=1 on the capture cycle.
//     -> all stalls=1, no capture; capture occurs the first cycle DM_stall=0.
//   DM_stall=1 for 3 cycles while LOCKED.
//     -> lock_forward_signal stays 1 for all 3, drops 1 cycle after DM_stall falls; stall_cnt += 3.
//   branch_taken=1 and lu=1 together.
//     -> load-use response only, IF_ID_flush=0, flush_cnt unchanged.
//     branch_taken alone -> IF_ID_flush=ID_EX_flush=1, flush_cnt += 1.
//   CNT_W=4: hold IM_stall 20 cycles -> stall_cnt saturates at 15.
//     Assert rst while LOCKED -> next cycle all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller placed after the forwarding unit.
// It turns load-use, branch-taken and memory-wait requests into per-stage
// stall and flush controls. It also owns the WB lock register. That register
// holds the WB result that would otherwise be lost while a load-use stall is
// in progress, and replays it to EX. Two saturating counters track stall
// cycles and branch flush events.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   load_use_stall_flush      load-use hazard from the forwarding unit
//   load_use_wb_lock_signal   other EX source comes from WB and must be locked
//   load_use_rs_lock_num      source to lock: 0=rs1, 1=rs2
//   WB_rd_data                value currently being written back
//   branch_taken              EX branch/jump resolved taken
//   IM_stall, DM_stall        instruction / data memory not ready
//   *_stall, *_flush          per-stage hold / bubble controls (combinational)
//   lock_forward_*            lock register valid / target source / data
//   stall_cnt, flush_cnt      saturating performance counters
module hazard_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use_stall_flush,
  input  logic              load_use_wb_lock_signal,
  input  logic              load_use_rs_lock_num,
  input  logic [DATA_W-1:0] WB_rd_data,
  input  logic              branch_taken,
  input  logic              IM_stall,
  input  logic              DM_stall,
  output logic              PC_stall,
  output logic              IF_ID_stall,
  output logic              ID_EX_stall,
  output logic              EX_MEM_stall,
  output logic              MEM_WB_stall,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic              EX_MEM_flush,
  output logic              lock_forward_signal,
  output logic              lock_forward_rs,
  output logic [DATA_W-1:0] lock_forward_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t state, state_nxt;
  logic   mem_wait, lu, capture, any_stall;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign mem_wait = IM_stall | DM_stall;
  // A second load-use report while locked refers to the same stalled instr.
  assign lu       = load_use_stall_flush & (state == IDLE);

  always_comb begin
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    capture      = 1'b0;
    state_nxt    = state;

    if (rst) begin
      state_nxt = IDLE;
    end else if (mem_wait) begin
      PC_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_stall = 1'b1;
    end else begin
      // The EX instr advances this cycle, so any held lock has been consumed.
      if (state == LOCKED) state_nxt = IDLE;
      if (lu) begin
        // Branch is ignored here because the EX instr is not yet valid.
        PC_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_stall  = 1'b1;
        EX_MEM_flush = 1'b1;
        if (load_use_wb_lock_signal) begin
          capture   = 1'b1;
          state_nxt = LOCKED;
        end
      end else if (branch_taken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end
    end
  end

  assign any_stall = PC_stall | IF_ID_stall | ID_EX_stall | EX_MEM_stall | MEM_WB_stall;
  assign lock_forward_signal = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      lock_forward_rs   <= 1'b0;
      lock_forward_data <= '0;
      stall_cnt         <= '0;
      flush_cnt         <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        lock_forward_data <= WB_rd_data;
        lock_forward_rs   <= load_use_rs_lock_num;
      end
      if (any_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (IF_ID_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
